// File: rtl/store_commit_queue.sv
// -----------------------------------------------------------------------------
// store_commit_queue
//
// Captures committed stores (SB/SH/SW) from the reorder buffer's memory-commit
// output in an in-order FIFO and drains them, one byte per cycle, to the
// byte-serial RAM port under a request/grant handshake with the memory
// arbiter. Non-store commit traffic is ignored. sq_full back-pressures commit.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   rdy                  global enable; low freezes every register
//   MC_output_valid      commit strobe
//   MC_OP_ID             committed op id (only `SB/`SH/`SW are captured)
//   MC_value, MC_addr    store data and byte address
//   sq_full, sq_empty    occupancy status (combinational)
//   mem_req, mem_gnt     RAM port request (registered) / arbiter grant
//   mem_a, mem_dout      RAM byte address / write byte (registered)
//   mem_wr               RAM write strobe (registered)
//   err_overflow         sticky: a store arrived while the queue was full
//   ld_probe_addr        load address probe
//   ld_probe_hit         a pending store covers the probed word
//
// Build option: define STORE_COMMIT_FWD_CHECK_EN to enable the load probe
// compare; otherwise ld_probe_hit is tied low and no compare logic exists.
// -----------------------------------------------------------------------------
`ifndef OpIdBus
`define OpIdBus 5:0
`endif
`ifndef DataWidth
`define DataWidth 31:0
`endif
`ifndef AddrWidth
`define AddrWidth 31:0
`endif
`ifndef SB
`define SB 6'd17
`endif
`ifndef SH
`define SH 6'd18
`endif
`ifndef SW
`define SW 6'd19
`endif

module store_commit_queue #(
   parameter int DEPTH = 8,
   parameter int PTR_W = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rdy,
   input  logic               MC_output_valid,
   input  logic [`OpIdBus]    MC_OP_ID,
   input  logic [`DataWidth]  MC_value,
   input  logic [`AddrWidth]  MC_addr,
   output logic               sq_full,
   output logic               sq_empty,
   output logic               mem_req,
   input  logic               mem_gnt,
   output logic [`AddrWidth]  mem_a,
   output logic [7:0]         mem_dout,
   output logic               mem_wr,
   output logic               err_overflow,
   input  logic [`AddrWidth]  ld_probe_addr,
   output logic               ld_probe_hit
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_REQ   = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_POP   = 2'd3;

   localparam logic [PTR_W:0] CNT_ZERO = (PTR_W+1)'(0);
   localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   // Entry storage: byte address, store data, index of the last byte (size-1)
   logic [31:0]      addr_mem_q  [0:DEPTH-1];
   logic [31:0]      value_mem_q [0:DEPTH-1];
   logic [1:0]       last_mem_q  [0:DEPTH-1];

   logic [PTR_W-1:0] head_q, tail_q;
   logic [PTR_W:0]   count_q, count_d;
   logic [1:0]       state_q, state_d;
   logic [1:0]       byte_idx_q, byte_idx_d;
   logic             mem_req_q, mem_req_d;
   logic             mem_wr_q, mem_wr_d;
   logic [31:0]      mem_a_q, mem_a_d;
   logic [7:0]       mem_dout_q, mem_dout_d;
   logic             err_overflow_q;

   logic             is_store_s;
   logic [1:0]       op_last_s;
   logic             enq_s, ovf_s, pop_s;
   logic [31:0]      head_addr_s, head_value_s;
   logic [1:0]       head_last_s;

   // Little-endian byte k of a 32-bit store value
   function automatic logic [7:0] sel_byte(input logic [31:0] v, input logic [1:0] k);
      logic [7:0] b;
      case (k)
         2'd0:    b = v[7:0];
         2'd1:    b = v[15:8];
         2'd2:    b = v[23:16];
         default: b = v[31:24];
      endcase
      return b;
   endfunction

   // Decode committed op into store / last-byte index
   always_comb begin
      is_store_s = 1'b0;
      op_last_s  = 2'd0;
      case (MC_OP_ID)
         `SB:     begin is_store_s = 1'b1; op_last_s = 2'd0; end
         `SH:     begin is_store_s = 1'b1; op_last_s = 2'd1; end
         `SW:     begin is_store_s = 1'b1; op_last_s = 2'd3; end
         default: begin is_store_s = 1'b0; op_last_s = 2'd0; end
      endcase
   end

   assign sq_full  = (count_q == CNT_FULL);
   assign sq_empty = (count_q == CNT_ZERO) && (state_q == ST_IDLE);

   // Full is judged on the registered count, so a POP in the same cycle
   // does not open a slot for the incoming store.
   assign enq_s = rdy & MC_output_valid & is_store_s & ~sq_full;
   assign ovf_s = rdy & MC_output_valid & is_store_s & sq_full;
   assign pop_s = rdy & (state_q == ST_POP);

   assign head_addr_s  = addr_mem_q[head_q];
   assign head_value_s = value_mem_q[head_q];
   assign head_last_s  = last_mem_q[head_q];

   // Occupancy next-state
   always_comb begin
      count_d = count_q;
      case ({enq_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Drain FSM and registered RAM-port outputs. mem_req is kept high across
   // WRITE/POP only while another entry is waiting behind the one in flight.
   always_comb begin
      state_d    = state_q;
      byte_idx_d = byte_idx_q;
      mem_req_d  = mem_req_q;
      mem_wr_d   = mem_wr_q;
      mem_a_d    = mem_a_q;
      mem_dout_d = mem_dout_q;
      case (state_q)
         ST_IDLE: begin
            if (count_q != CNT_ZERO) begin
               state_d   = ST_REQ;
               mem_req_d = 1'b1;
            end else begin
               mem_req_d = 1'b0;
            end
         end
         ST_REQ: begin
            if (mem_gnt) begin
               state_d    = ST_WRITE;
               byte_idx_d = 2'd0;
               mem_wr_d   = 1'b1;
               mem_a_d    = head_addr_s;
               mem_dout_d = sel_byte(head_value_s, 2'd0);
               mem_req_d  = (count_d > CNT_ONE);
            end else begin
               mem_req_d = 1'b1;
            end
         end
         ST_WRITE: begin
            if (byte_idx_q == head_last_s) begin
               state_d    = ST_POP;
               mem_wr_d   = 1'b0;
               mem_a_d    = 32'd0;
               mem_dout_d = 8'd0;
               mem_req_d  = (count_d > CNT_ONE);
            end else begin
               byte_idx_d = byte_idx_q + 2'd1;
               mem_a_d    = head_addr_s + {30'd0, byte_idx_d};
               mem_dout_d = sel_byte(head_value_s, byte_idx_d);
               mem_req_d  = (count_d > CNT_ONE);
            end
         end
         ST_POP: begin
            byte_idx_d = 2'd0;
            if (count_d != CNT_ZERO) begin
               state_d   = ST_REQ;
               mem_req_d = 1'b1;
            end else begin
               state_d   = ST_IDLE;
               mem_req_d = 1'b0;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            byte_idx_d = 2'd0;
            mem_req_d  = 1'b0;
            mem_wr_d   = 1'b0;
            mem_a_d    = 32'd0;
            mem_dout_d = 8'd0;
         end
      endcase
   end

   // Control state, pointers and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         state_q        <= ST_IDLE;
         byte_idx_q     <= 2'd0;
         mem_req_q      <= 1'b0;
         mem_wr_q       <= 1'b0;
         mem_a_q        <= 32'd0;
         mem_dout_q     <= 8'd0;
         err_overflow_q <= 1'b0;
      end else if (rdy) begin
         count_q    <= count_d;
         state_q    <= state_d;
         byte_idx_q <= byte_idx_d;
         mem_req_q  <= mem_req_d;
         mem_wr_q   <= mem_wr_d;
         mem_a_q    <= mem_a_d;
         mem_dout_q <= mem_dout_d;
         if (enq_s) begin
            tail_q <= tail_q + PTR_ONE;
         end
         if (pop_s) begin
            head_q <= head_q + PTR_ONE;
         end
         if (ovf_s) begin
            err_overflow_q <= 1'b1;
         end
      end
   end

   // Entry payload write; contents are qualified by the pointers, so no reset
   always_ff @(posedge clk) begin
      if (enq_s) begin
         addr_mem_q[tail_q]  <= MC_addr;
         value_mem_q[tail_q] <= MC_value;
         last_mem_q[tail_q]  <= op_last_s;
      end
   end

   assign mem_req      = mem_req_q;
   assign mem_wr       = mem_wr_q;
   assign mem_a        = mem_a_q;
   assign mem_dout     = mem_dout_q;
   assign err_overflow = err_overflow_q;

`ifdef STORE_COMMIT_FWD_CHECK_EN
   logic [DEPTH-1:0] valid_q;
   logic             probe_hit_s;

   // Per-entry valid bits: set on enqueue, cleared when the entry pops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
      end else if (rdy) begin
         if (enq_s) begin
            valid_q[tail_q] <= 1'b1;
         end
         if (pop_s) begin
            valid_q[head_q] <= 1'b0;
         end
      end
   end

   // Word-granular overlap of the probe against every pending store
   always_comb begin
      probe_hit_s = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (addr_mem_q[i][31:2] == ld_probe_addr[31:2])) begin
            probe_hit_s = 1'b1;
         end else begin
            probe_hit_s = probe_hit_s;
         end
      end
   end

   assign ld_probe_hit = probe_hit_s;
`else
   logic unused_probe_s;
   assign unused_probe_s = ^ld_probe_addr;
   assign ld_probe_hit   = 1'b0;
`endif

endmodule

// File: tb/tb_store_commit_queue.sv
`ifndef OpIdBus
`define OpIdBus 5:0
`endif
`ifndef DataWidth
`define DataWidth 31:0
`endif
`ifndef AddrWidth
`define AddrWidth 31:0
`endif
`ifndef SB
`define SB 6'd17
`endif
`ifndef SH
`define SH 6'd18
`endif
`ifndef SW
`define SW 6'd19
`endif

module tb_store_commit_queue;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              rdy = 1'b1;
   logic              MC_output_valid = 1'b0;
   logic [`OpIdBus]   MC_OP_ID = '0;
   logic [`DataWidth] MC_value = '0;
   logic [`AddrWidth] MC_addr = '0;
   logic              sq_full, sq_empty, mem_req, mem_wr, err_overflow, ld_probe_hit;
   logic              mem_gnt = 1'b0;
   logic [`AddrWidth] mem_a;
   logic [7:0]        mem_dout;
   logic [`AddrWidth] ld_probe_addr = '0;

   localparam logic [`OpIdBus] OP_BEQ = 6'd5;

   int checks = 0;
   int failures = 0;

   logic [31:0] log_a[$];
   logic [7:0]  log_d[$];
   logic [31:0] exp_a[$];
   logic [7:0]  exp_d[$];

   store_commit_queue #(.DEPTH(8), .PTR_W(3)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .MC_output_valid(MC_output_valid), .MC_OP_ID(MC_OP_ID),
      .MC_value(MC_value), .MC_addr(MC_addr),
      .sq_full(sq_full), .sq_empty(sq_empty),
      .mem_req(mem_req), .mem_gnt(mem_gnt),
      .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
      .err_overflow(err_overflow),
      .ld_probe_addr(ld_probe_addr), .ld_probe_hit(ld_probe_hit)
   );

   always #5 clk = ~clk;

   // Record every RAM byte write as seen by the RAM (once per enabled cycle)
   always @(negedge clk) begin
      if (!rst && rdy && mem_wr) begin
         log_a.push_back(mem_a);
         log_d.push_back(mem_dout);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic commit(input logic [`OpIdBus] op, input logic [31:0] a, input logic [31:0] v);
      MC_output_valid = 1'b1;
      MC_OP_ID = op;
      MC_addr = a;
      MC_value = v;
      tick();
      MC_output_valid = 1'b0;
   endtask

   task automatic expect_store(input logic [31:0] a, input logic [31:0] v, input int n);
      logic [31:0] sh;
      for (int k = 0; k < n; k++) begin
         sh = v >> (8 * k);
         exp_a.push_back(a + k);
         exp_d.push_back(sh[7:0]);
      end
   endtask

   task automatic clear_logs();
      log_a.delete();
      log_d.delete();
      exp_a.delete();
      exp_d.delete();
   endtask

   task automatic compare_log(input string tag);
      check_eq({tag, "_nbytes"}, log_a.size(), exp_a.size());
      for (int i = 0; i < log_a.size() && i < exp_a.size(); i++) begin
         check_eq($sformatf("%s_addr%0d", tag, i), log_a[i], exp_a[i]);
         check_eq($sformatf("%s_data%0d", tag, i), {24'd0, log_d[i]}, {24'd0, exp_d[i]});
      end
   endtask

   task automatic wait_idle(input string tag, input int budget);
      for (int i = 0; i < budget && !sq_empty; i++) tick();
      check_eq({tag, "_drain_done"}, sq_empty, 1'b1);
   endtask

   task automatic wait_byte(input string tag, input logic [31:0] a, input int budget);
      for (int i = 0; i < budget && !(mem_wr && mem_a == a); i++) tick();
      check_eq({tag, "_byte_seen"}, (mem_wr && mem_a == a), 1'b1);
   endtask

   initial begin
      logic [7:0] sw_bytes [4];
      sw_bytes[0] = 8'hD4; sw_bytes[1] = 8'hC3; sw_bytes[2] = 8'hB2; sw_bytes[3] = 8'hA1;

      // ---------------- reset state ----------------
      tick(); tick();
      check_eq("rst_mem_req", mem_req, 1'b0);
      check_eq("rst_mem_wr", mem_wr, 1'b0);
      rst = 1'b0;
      tick();
      check_eq("rst_empty", sq_empty, 1'b1);
      check_eq("rst_full", sq_full, 1'b0);
      check_eq("rst_mem_a", mem_a, 32'd0);
      check_eq("rst_mem_dout", mem_dout, 8'd0);
      check_eq("rst_err", err_overflow, 1'b0);
      check_eq("rst_hit", ld_probe_hit, 1'b0);

      // ---------------- single SW, grant held ----------------
      clear_logs();
      mem_gnt = 1'b1;
      commit(`SW, 32'h100, 32'hA1B2C3D4);
      check_eq("sw_not_empty", sq_empty, 1'b0);
      check_eq("sw_no_req_yet", mem_req, 1'b0);
      tick();
      check_eq("sw_req", mem_req, 1'b1);
      check_eq("sw_no_wr_yet", mem_wr, 1'b0);
      for (int k = 0; k < 4; k++) begin
         tick();
         check_eq($sformatf("sw_wr%0d", k), mem_wr, 1'b1);
         check_eq($sformatf("sw_a%0d", k), mem_a, 32'h100 + k);
         check_eq($sformatf("sw_d%0d", k), mem_dout, sw_bytes[k]);
      end
      tick();
      check_eq("sw_pop_wr", mem_wr, 1'b0);
      check_eq("sw_pop_not_empty", sq_empty, 1'b0);
      tick();
      check_eq("sw_done_empty", sq_empty, 1'b1);
      check_eq("sw_done_req", mem_req, 1'b0);

      // ---------------- mixed ops ----------------
      clear_logs();
      commit(OP_BEQ, 32'h40, 32'hFFFF_FFFF);
      tick();
      check_eq("beq_ignored_empty", sq_empty, 1'b1);
      check_eq("beq_ignored_req", mem_req, 1'b0);
      commit(`SB, 32'h20, 32'h0000_0055);
      commit(`SH, 32'h31, 32'h0000_1234);
      expect_store(32'h20, 32'h55, 1);
      expect_store(32'h31, 32'h1234, 2);
      wait_idle("mixed", 60);
      compare_log("mixed");

      // ---------------- full and overflow ----------------
      clear_logs();
      mem_gnt = 1'b0;
      for (int i = 0; i < 8; i++) begin
         commit(`SW, 32'h400 + 4 * i, 32'h1020_3040 + i);
         expect_store(32'h400 + 4 * i, 32'h1020_3040 + i, 4);
      end
      check_eq("full_set", sq_full, 1'b1);
      check_eq("full_no_err_yet", err_overflow, 1'b0);
      check_eq("full_req", mem_req, 1'b1);
      check_eq("full_no_wr", mem_wr, 1'b0);
      commit(`SW, 32'h500, 32'hDEAD_BEEF);
      check_eq("ovf_err", err_overflow, 1'b1);
      check_eq("ovf_still_full", sq_full, 1'b1);
      mem_gnt = 1'b1;
      tick();
      check_eq("ovf_full_until_pop", sq_full, 1'b1);
      wait_idle("full", 200);
      compare_log("full");
      check_eq("ovf_sticky", err_overflow, 1'b1);

      // ---------------- grant delay and rdy freeze ----------------
      clear_logs();
      mem_gnt = 1'b0;
      commit(`SB, 32'h60, 32'h0000_005A);
      tick();
      for (int i = 0; i < 5; i++) begin
         check_eq($sformatf("gdly_req%0d", i), mem_req, 1'b1);
         check_eq($sformatf("gdly_nowr%0d", i), mem_wr, 1'b0);
         tick();
      end
      commit(`SW, 32'h80, 32'hCAFE_F00D);
      expect_store(32'h60, 32'h5A, 1);
      expect_store(32'h80, 32'hCAFE_F00D, 4);
      mem_gnt = 1'b1;
      wait_byte("frz", 32'h81, 30);
      rdy = 1'b0;
      MC_output_valid = 1'b1;
      MC_OP_ID = `SB;
      MC_addr = 32'h90;
      MC_value = 32'h77;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq($sformatf("frz_a%0d", i), mem_a, 32'h81);
         check_eq($sformatf("frz_d%0d", i), mem_dout, 8'hF0);
         check_eq($sformatf("frz_wr%0d", i), mem_wr, 1'b1);
      end
      MC_output_valid = 1'b0;
      rdy = 1'b1;
      wait_idle("frz", 60);
      compare_log("frz");

      // ---------------- async reset mid-WRITE ----------------
      mem_gnt = 1'b1;
      commit(`SW, 32'h300, 32'h0102_0304);
      commit(`SW, 32'h304, 32'h0506_0708);
      wait_byte("arst", 32'h301, 30);
      check_eq("arst_req_before", mem_req, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check_eq("arst_wr", mem_wr, 1'b0);
      check_eq("arst_req", mem_req, 1'b0);
      check_eq("arst_empty", sq_empty, 1'b1);
      check_eq("arst_err", err_overflow, 1'b0);
      tick();
      rst = 1'b0;
      clear_logs();
      tick(); tick(); tick();
      check_eq("arst_stay_empty", sq_empty, 1'b1);
      check_eq("arst_no_writes", log_a.size(), 0);

      // ---------------- load probe ----------------
      mem_gnt = 1'b0;
      commit(`SW, 32'h200, 32'h1111_2222);
      ld_probe_addr = 32'h202;
      #1;
`ifdef STORE_COMMIT_FWD_CHECK_EN
      check_eq("probe_hit_202", ld_probe_hit, 1'b1);
      ld_probe_addr = 32'h204;
      #1;
      check_eq("probe_miss_204", ld_probe_hit, 1'b0);
      mem_gnt = 1'b1;
      wait_idle("probe", 40);
      ld_probe_addr = 32'h202;
      #1;
      check_eq("probe_after_pop", ld_probe_hit, 1'b0);
`else
      check_eq("probe_tied_low", ld_probe_hit, 1'b0);
      mem_gnt = 1'b1;
      wait_idle("probe", 40);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/store_commit_queue.md
Name: store_commit_queue

Overview:
- Sits directly downstream of the reorder buffer's memory-commit output.
- Captures committed stores (SB/SH/SW) in an in-order FIFO and drains them to the byte-serial RAM port, one byte per cycle, under a request/grant handshake with the memory arbiter.
- Non-store commit traffic is ignored.
- Back-pressures commit via sq_full.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- PTR_W, 3, log2(DEPTH).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- rdy  in  1  global enable; low freezes all state
- MC_output_valid  in  1  commit strobe from reorder buffer
- MC_OP_ID  in  `OpIdBus  committed op id
- MC_value  in  `DataWidth  store data
- MC_addr  in  `AddrWidth  store byte address
- sq_full  out  1  count == DEPTH
- sq_empty  out  1  count == 0 and FSM idle
- mem_req  out  1  request for RAM port
- mem_gnt  in  1  arbiter grant; sampled each cycle
- mem_a  out  `AddrWidth  RAM byte address
- mem_dout  out  8  RAM write byte
- mem_wr  out  1  RAM write strobe
- err_overflow  out  1  sticky: store dropped while full
- ld_probe_addr  in  `AddrWidth  load address probe (see Optional Feature)
- ld_probe_hit  out  1  pending store overlaps probe word

Behaviour:
- Reset (async): head=0, tail=0, count=0, state=IDLE, byte_idx=0, err_overflow=0. Outputs mem_req, mem_wr, mem_a, mem_dout are all 0.
- rdy=0: no state, pointer or output register changes. A commit offered in that cycle is ignored.
- Enqueue:
  - Condition: rdy & MC_output_valid & op in {`SB,`SH,`SW} & !full.
  - Writes {op size, addr, value} to the tail entry; tail wraps DEPTH-1 -> 0.
  - Other ops (branches, JAL targets, etc.) are ignored, with no state change.
- Store while full: store dropped, err_overflow <= 1 and held until reset.
- Size encoding: SB=1 byte, SH=2 bytes, SW=4 bytes. Byte k = value[8k+7:8k] at addr+k (little-endian); address adds are 32-bit and wrap.
- Drain FSM, registered outputs:
  - IDLE: if count!=0 -> REQ with mem_req=1.
  - REQ: hold mem_req=1 until mem_gnt=1 is sampled. On that edge -> WRITE, byte_idx=0, and drive mem_wr=1, mem_a=addr, mem_dout=byte 0.
  - WRITE: each cycle advance byte_idx and drive the next byte. After the last byte has been driven for one cycle -> POP.
  - POP: mem_wr=0; head++ (wrap), count--. Then -> REQ if count after pop != 0, else -> IDLE, with mem_req=0.
  - mem_req stays 1 through WRITE and POP when a further entry is pending.
  - Grant is not rechecked mid-store; a granted store completes atomically.
- Latency and throughput:
  - Empty queue, grant held high: first mem_wr 2 cycles after the enqueue edge.
  - SW occupies 4 write cycles plus 1 POP cycle.
- Simultaneous enqueue and POP in one cycle: count unchanged, both pointers move.
- sq_full is combinational from count. Enqueue with count==DEPTH is refused even if POP happens in the same cycle.
- Reset mid-store: partially written bytes stay in RAM; the queue is cleared. This is accepted: commit order guarantees reset only at boot.

Optional Feature:
- Macro STORE_COMMIT_FWD_CHECK_EN.
- Defined:
  - ld_probe_hit is combinational, 1 when any valid entry (head..tail-1, including the one draining) has addr[31:2] equal to ld_probe_addr[31:2].
  - Entries must be tracked with a per-entry valid bit.
  - Loads use this to stall until the store drains.
- Undefined: ld_probe_hit tied 0 and ld_probe_addr unused; no per-entry valid compare logic is synthesised.

Test Plan:
- Single SW: commit SW addr=0x100, value=0xA1B2C3D4, grant held 1 -> mem_wr on 4 consecutive cycles at 0x100..0x103, data D4,C3,B2,A1; then sq_empty=1.
- Mixed ops: commit BEQ, then SB 0x20 value 0x55, then SH 0x31 value 0x1234 -> BEQ ignored; writes 0x20:55, then 0x31:34, 0x32:12, in order.
- Full and overflow:
  - Grant held 0, commit 8 SW -> sq_full=1.
  - A 9th SW sets err_overflow=1, and count stays 8.
  - Releasing grant drains 32 bytes in commit order.
- Grant delay and rdy freeze:
  - Grant held low 5 cycles with one SB queued -> mem_req=1 steady and mem_wr=0.
  - Then rdy=0 for 3 cycles mid-SW -> byte_idx and mem_a frozen; resume completes correctly.
- Async reset mid-WRITE: assert rst between edges -> mem_wr, mem_req and count drop to 0 immediately, without waiting for a clock edge.
- With STORE_COMMIT_FWD_CHECK_EN: SW 0x200 pending, probe 0x202 -> hit=1; probe 0x204 -> hit=0; after POP, probe 0x202 -> hit=0.
